// File: rtl/morra_torneo_ctrl.sv
// Tournament sequencer for the MorraCinese game FSM: collects move pairs, issues them,
// tallies partite. Build macro MORRA_TIMEOUT_EN adds a second-move forfeit timeout.
module morra_torneo_ctrl #(
    parameter int N_PARTITE   = 3,
    parameter int W           = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         START,
    input  logic         M1_VALID,
    input  logic [1:0]   M1,
    output logic         M1_READY,
    input  logic         M2_VALID,
    input  logic [1:0]   M2,
    output logic         M2_READY,
    output logic [1:0]   PRIMO,
    output logic [1:0]   SECONDO,
    output logic         INIZIO,
    input  logic [1:0]   MANCHE,
    input  logic [1:0]   PARTITA,
    output logic [1:0]   MANCHE_OUT,
    output logic [W-1:0] VINTE1,
    output logic [W-1:0] VINTE2,
    output logic [1:0]   TORNEO,
`ifdef MORRA_TIMEOUT_EN
    output logic         TIMEOUT_EVT,
`endif
    output logic         BUSY,
    output logic         DONE
);

    if ((N_PARTITE < 1) || (N_PARTITE > 15) || ((N_PARTITE % 2) == 0) ||
        ((1 << W) <= N_PARTITE) || (TIMEOUT_CYC < 1)) begin : g_param_check
        $error("morra_torneo_ctrl: invalid parameter set");
    end

    localparam logic [W-1:0] HALF = W'(N_PARTITE / 2);
    localparam logic [W-1:0] NP   = W'(N_PARTITE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_ISSUE   = 3'd2,
        S_RESULT  = 3'd3,
        S_FINE    = 3'd4
    } state_t;

    state_t         state_r;
    logic [1:0]     lat1_r, lat2_r;
    logic           lat1_v_r, lat2_v_r;
    logic           first_manche_r;
    logic [W-1:0]   idx_r;

    logic           hs1_s, hs2_s, both_s, part_end_s, fine_s;
    logic [1:0]     primo_s, secondo_s, p_code_s, torneo_nxt_s;
    logic [W-1:0]   v1_nxt_s, v2_nxt_s, idx_nxt_s;

`ifdef MORRA_TIMEOUT_EN
    localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]  tmo_cnt_r;
    logic           tmo_fire_s;
    logic           tmo_run_s;
`endif

    // Handshakes, partita-end detection and next counter values shared by RESULT and timeout
    always_comb begin
        hs1_s     = (state_r == S_COLLECT) && M1_VALID && M1_READY && (M1 != 2'b00);
        hs2_s     = (state_r == S_COLLECT) && M2_VALID && M2_READY && (M2 != 2'b00);
        both_s    = (lat1_v_r || hs1_s) && (lat2_v_r || hs2_s);
        primo_s   = hs1_s ? M1 : lat1_r;
        secondo_s = hs2_s ? M2 : lat2_r;
`ifdef MORRA_TIMEOUT_EN
        tmo_run_s  = (state_r == S_COLLECT) && (lat1_v_r != lat2_v_r) && !both_s;
        tmo_fire_s = tmo_run_s && (tmo_cnt_r == TMO_LAST);
        if (tmo_fire_s) begin
            p_code_s = lat1_v_r ? 2'b01 : 2'b10;
        end else begin
            p_code_s = PARTITA;
        end
        part_end_s = tmo_fire_s ||
                     ((state_r == S_RESULT) && (MANCHE != 2'b00) && (PARTITA != 2'b00));
`else
        p_code_s   = PARTITA;
        part_end_s = (state_r == S_RESULT) && (MANCHE != 2'b00) && (PARTITA != 2'b00);
`endif
        v1_nxt_s  = VINTE1 + W'(p_code_s == 2'b01);
        v2_nxt_s  = VINTE2 + W'(p_code_s == 2'b10);
        idx_nxt_s = idx_r + W'(1);
        fine_s    = (v1_nxt_s > HALF) || (v2_nxt_s > HALF) || (idx_nxt_s == NP);
        if (v1_nxt_s > v2_nxt_s) begin
            torneo_nxt_s = 2'b01;
        end else if (v2_nxt_s > v1_nxt_s) begin
            torneo_nxt_s = 2'b10;
        end else begin
            torneo_nxt_s = 2'b11;
        end
    end

    // Sequencer: state, move latches, tallies and every registered output
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_r        <= S_IDLE;
            lat1_r         <= 2'b00;
            lat2_r         <= 2'b00;
            lat1_v_r       <= 1'b0;
            lat2_v_r       <= 1'b0;
            first_manche_r <= 1'b0;
            idx_r          <= '0;
            M1_READY       <= 1'b0;
            M2_READY       <= 1'b0;
            PRIMO          <= 2'b00;
            SECONDO        <= 2'b00;
            INIZIO         <= 1'b0;
            MANCHE_OUT     <= 2'b00;
            VINTE1         <= '0;
            VINTE2         <= '0;
            TORNEO         <= 2'b00;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
`ifdef MORRA_TIMEOUT_EN
            tmo_cnt_r      <= '0;
            TIMEOUT_EVT    <= 1'b0;
`endif
        end else begin
`ifdef MORRA_TIMEOUT_EN
            TIMEOUT_EVT <= 1'b0;
            if (tmo_run_s && !tmo_fire_s) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end else begin
                tmo_cnt_r <= '0;
            end
`endif
            case (state_r)
                S_IDLE, S_FINE: begin
                    if (START) begin
                        state_r        <= S_COLLECT;
                        lat1_v_r       <= 1'b0;
                        lat2_v_r       <= 1'b0;
                        first_manche_r <= 1'b1;
                        idx_r          <= '0;
                        M1_READY       <= 1'b1;
                        M2_READY       <= 1'b1;
                        MANCHE_OUT     <= 2'b00;
                        VINTE1         <= '0;
                        VINTE2         <= '0;
                        TORNEO         <= 2'b00;
                        BUSY           <= 1'b1;
                        DONE           <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (hs1_s) begin
                        lat1_r   <= M1;
                        lat1_v_r <= 1'b1;
                        M1_READY <= 1'b0;
                    end
                    if (hs2_s) begin
                        lat2_r   <= M2;
                        lat2_v_r <= 1'b1;
                        M2_READY <= 1'b0;
                    end
                    if (both_s) begin
                        state_r <= S_ISSUE;
                        PRIMO   <= primo_s;
                        SECONDO <= secondo_s;
                        INIZIO  <= first_manche_r;
                    end
                end
                S_ISSUE: begin
                    state_r <= S_RESULT;
                    PRIMO   <= 2'b00;
                    SECONDO <= 2'b00;
                    INIZIO  <= 1'b0;
                end
                S_RESULT: begin
                    // A rejected pair (MANCHE=00) keeps first_manche so INIZIO is retried
                    state_r    <= S_COLLECT;
                    MANCHE_OUT <= MANCHE;
                    lat1_v_r   <= 1'b0;
                    lat2_v_r   <= 1'b0;
                    M1_READY   <= 1'b1;
                    M2_READY   <= 1'b1;
                    if (MANCHE != 2'b00) begin
                        first_manche_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
            if (part_end_s) begin
                VINTE1         <= v1_nxt_s;
                VINTE2         <= v2_nxt_s;
                idx_r          <= idx_nxt_s;
                first_manche_r <= 1'b1;
                lat1_v_r       <= 1'b0;
                lat2_v_r       <= 1'b0;
`ifdef MORRA_TIMEOUT_EN
                TIMEOUT_EVT    <= tmo_fire_s;
`endif
                if (fine_s) begin
                    state_r  <= S_FINE;
                    BUSY     <= 1'b0;
                    DONE     <= 1'b1;
                    TORNEO   <= torneo_nxt_s;
                    M1_READY <= 1'b0;
                    M2_READY <= 1'b0;
                end else begin
                    state_r  <= S_COLLECT;
                    M1_READY <= 1'b1;
                    M2_READY <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/morra_torneo_ctrl.md
Name: morra_torneo_ctrl

Overview:
- Tournament sequencer for the MorraCinese game FSM.
- Accepts one move per manche from each of two players through valid/ready handshakes, presents each move pair to the game FSM for exactly one cycle, and drives INIZIO on the first manche of each partita.
- Reads MANCHE/PARTITA back, tallies partite won, and declares the tournament winner over a best-of-N_PARTITE series.

Parameters:
- N_PARTITE, 3: maximum partite per tournament; odd, range 1..15.
- W, 4: width of the win counters; must satisfy 2^W > N_PARTITE.
- TIMEOUT_CYC, 255: cycles allowed for the second move after the first is latched (used only with MORRA_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse that begins a tournament
- M1_VALID  in  1  player 1 move valid
- M1  in  2  player 1 move: 01 sasso, 10 carta, 11 forbice, 00 illegal
- M1_READY  out  1  controller accepts the player 1 move
- M2_VALID  in  1  player 2 move valid
- M2  in  2  player 2 move, same encoding as M1
- M2_READY  out  1  controller accepts the player 2 move
- PRIMO  out  2  move to game FSM
- SECONDO  out  2  move to game FSM
- INIZIO  out  1  first-manche flag to game FSM
- MANCHE  in  2  game FSM result: 00 invalid, 01 P1, 10 P2, 11 tie
- PARTITA  in  2  game FSM result: 00 ongoing, 01 P1, 10 P2, 11 tie
- MANCHE_OUT  out  2  registered copy of the last sampled MANCHE
- VINTE1  out  W  partite won by player 1
- VINTE2  out  W  partite won by player 2
- TORNEO  out  2  tournament result: 00 none, 01 P1, 10 P2, 11 tie
- BUSY  out  1  tournament in progress
- DONE  out  1  tournament finished

Behaviour:
- Reset values: all outputs 0; state IDLE; latches, counters and partita index cleared.
- RESET takes priority in every state and aborts any tournament in progress.
- Game FSM contract: its outputs are registered one cycle after inputs are applied. When PRIMO=00 or SECONDO=00 it holds its state.
- PRIMO, SECONDO and INIZIO are 00/00/0 in every state except ISSUE.
- States: IDLE, COLLECT, ISSUE, RESULT, FINE.
- IDLE:
  - START moves to COLLECT.
  - On entry to COLLECT: VINTE1, VINTE2, TORNEO, MANCHE_OUT, DONE and the partita index are cleared; first_manche is set to 1.
- COLLECT:
  - Mx_READY is high while that player's move is not yet latched.
  - A handshake requires Mx_VALID & Mx_READY & Mx != 00; it latches the move and drops Mx_READY next cycle.
  - Mx=00 with VALID high is ignored; READY stays high.
  - The two players may handshake in the same cycle or in different cycles.
  - When both moves are latched, go to ISSUE on the next edge.
- ISSUE (exactly one cycle):
  - PRIMO/SECONDO = latched moves; INIZIO = first_manche.
  - Then go to RESULT.
- RESULT:
  - Sample MANCHE into MANCHE_OUT and clear both latches.
  - MANCHE=00: back to COLLECT; first_manche unchanged; the game FSM rejected the pair.
  - Otherwise first_manche := 0.
  - PARTITA=00: go to COLLECT.
  - PARTITA=01: increment VINTE1. PARTITA=10: increment VINTE2. PARTITA=11: no increment.
  - Any PARTITA != 00: increment the partita index and set first_manche := 1.
  - Go to FINE when a counter (after update) exceeds N_PARTITE/2 or the index reaches N_PARTITE; else go to COLLECT.
- Latency: second handshake at edge k → ISSUE during cycle k..k+1 → counters/MANCHE_OUT updated at edge k+2.
- FINE:
  - DONE=1, BUSY=0.
  - TORNEO = 01 if VINTE1 > VINTE2, 10 if VINTE2 > VINTE1, 11 if equal.
  - Outputs hold until START, which returns to COLLECT with counters cleared.
- BUSY = 1 in COLLECT, ISSUE and RESULT. START there is ignored.
- Counters never wrap: they are bounded by N_PARTITE < 2^W.

Optional Feature:
- Macro: MORRA_TIMEOUT_EN.
- Enabled:
  - A counter starts when exactly one move is latched in COLLECT.
  - If TIMEOUT_CYC cycles elapse without the second move, the partita is forfeited to the player who moved: increment that player's counter and the partita index, set first_manche := 1, clear the latches.
  - Output TIMEOUT_EVT (out, 1) pulses for one cycle.
  - Then apply the same FINE/COLLECT decision as RESULT.
- Disabled: no counter and no TIMEOUT_EVT port; COLLECT waits indefinitely.

Test Plan:
- Reset mid-RESULT: assert RESET in RESULT → next cycle IDLE, all outputs 0, PRIMO/SECONDO 00.
- First manche: START, then M1=01 and M2=11 in the same cycle → one ISSUE cycle with PRIMO=01, SECONDO=11, INIZIO=1. Game FSM returns MANCHE=01 → MANCHE_OUT=01 two edges after the handshake.
- Illegal and staggered moves: M1=00 with VALID → M1_READY stays 1, nothing latched. M1=10 at cycle 3, M2=01 at cycle 7 → ISSUE at cycle 8 only.
- Early finish: partite won by P1, P1 (N_PARTITE=3) → VINTE1=2, FINE, TORNEO=01, DONE=1. START while BUSY is ignored.
- Tied tournament: N_PARTITE=3 with results tie, P1, P2 → FINE after 3 partite, TORNEO=11, VINTE1=VINTE2=1.
- Timeout (MORRA_TIMEOUT_EN, TIMEOUT_CYC=4): M2 latched, M1 idle for 4 cycles → TIMEOUT_EVT pulse, VINTE2 increments, next ISSUE has INIZIO=1.
